adc733_sport_responder: RTL and testbench

- Synthesizable model of the ADC's serial-port side: the device end of the SCLK/SDIFS/SDI/SDOFS/SDO/SE link the host controller drives.
- Generates SCLK, captures 16-bit control words into an 8-entry register file, echoes them in program mode, then streams NUM_CH channel samples per sample period once a data-mode word arrives.
- Used for FPGA loopback and for benches without a real converter.

---
 rtl/adc733_pkg.sv | 32 +++
 rtl/adc733_sport_txframe.sv | 65 ++++++
 rtl/adc733_sport_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_adc733_sport_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc733_pkg.sv
// Shared constants, types and helpers for the ADC733 serial-port responder.
// Word layout: bit15 MODE (1 = data-mode request), bit14 CTRL (must be 1),
// bits13:8 ignored, bits7:0 DATA. Burst frames carry {1, chan[2:0], sample[11:0]}.
package adc733_pkg;

  localparam int WORD_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int PTR_W     = 4;   // pointer runs 0..NUM_REGS inclusive
  localparam int MODE_BIT  = 15;
  localparam int CTRL_BIT  = 14;
  localparam int DATA_MSB  = 7;
  localparam int CHAN_MSB  = 14;
  localparam int CHAN_LSB  = 12;
  localparam int SAMP_W    = CHAN_LSB;
  localparam int FPOS_W    = 5;   // frame position 0..16 (sync + 16 bits)

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t                   WORD_RST = '0;
  localparam logic [NUM_REGS*8-1:0]   CFG_RST  = '0;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_e;

  function automatic word_t burst_word(input logic [CHAN_MSB-CHAN_LSB:0] chan,
                                       input logic [SAMP_W-1:0] samp);
    return {1'b1, chan, samp};
  endfunction

endpackage

// File: rtl/adc733_sport_txframe.sv
// One transmit frame engine: SDOFS high for one SCLK period, then 16 bits
// MSB first, all advanced by fall_en.
//   clk, rst_l : system clock, async active-low reset
//   fall_en    : one-clk strobe at each SCLK 1->0 edge
//   start      : with fall_en, begin a frame carrying `load`
//   abort      : drop any frame immediately (sdofs/sdo to 0)
//   load       : word to send
//   busy       : frame occupies the next SCLK period (a start must wait)
//   sdofs, sdo : registered frame sync and data
module adc733_sport_txframe
  import adc733_pkg::*;
(
  input  logic  clk,
  input  logic  rst_l,
  input  logic  fall_en,
  input  logic  start,
  input  logic  abort,
  input  word_t load,
  output logic  busy,
  output logic  sdofs,
  output logic  sdo
);

  word_t             sh;
  logic              active;
  logic [FPOS_W-1:0] pos;   // 0 = sync period, 1..16 = data bits

  // In the last bit period a new frame may start on the next fall, which
  // gives back-to-back frames of exactly 17 SCLK periods.
  assign busy = active && (pos != FPOS_W'(WORD_W));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sh     <= WORD_RST;
      active <= 1'b0;
      pos    <= '0;
      sdofs  <= 1'b0;
      sdo    <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
      pos    <= '0;
      sdofs  <= 1'b0;
      sdo    <= 1'b0;
    end else if (fall_en) begin
      if (start) begin
        sh     <= load;
        active <= 1'b1;
        pos    <= '0;
        sdofs  <= 1'b1;
        sdo    <= 1'b0;
      end else if (active) begin
        sdofs <= 1'b0;
        if (pos == FPOS_W'(WORD_W)) begin
          active <= 1'b0;
          sdo    <= 1'b0;
        end else begin
          sdo <= sh[WORD_W-1];
          sh  <= {sh[WORD_W-2:0], 1'b0};
          pos <= pos + FPOS_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc733_sport_responder.sv
// Device end of the ADC733 serial link: generates SCLK, receives 16-bit
// control words, fills an 8-entry register file, echoes program words and,
// after a data-mode word, streams NUM_CH sample frames every SAMPLE_PERIOD
// SCLK periods.
//   clk, rst_l  : system clock, async active-low reset
//   SCLK        : divided serial clock (register, not a clock net)
//   SDIFS, SDI  : host frame sync / data, sampled on SCLK rise
//   SE          : port enable; low gates SDO/SDOFS and the receiver
//   SDOFS, SDO  : output frame sync / data, change on SCLK fall
//   ch_data     : per-channel samples, channel 0 in [15:0]
//   cfg_regs    : register file, CRA in [7:0] .. CRH in [63:56]
//   data_mode   : sticky once a data-mode word is accepted
//   rx_word, rx_valid : last received word and its one-clk update pulse
//   cfg_err     : sticky, program word arrived with the file already full
module adc733_sport_responder
  import adc733_pkg::*;
#(
  parameter int CLK_DIV       = 1,
  parameter int NUM_CH        = 6,
  parameter int SAMPLE_PERIOD = 256
) (
  input  logic                   clk,
  input  logic                   rst_l,
  output logic                   SCLK,
  input  logic                   SDIFS,
  input  logic                   SDI,
  input  logic                   SE,
  output logic                   SDOFS,
  output logic                   SDO,
  input  logic [16*NUM_CH-1:0]   ch_data,
  output logic [NUM_REGS*8-1:0]  cfg_regs,
  output logic                   data_mode,
  output word_t                  rx_word,
  output logic                   rx_valid,
  output logic                   cfg_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SC_W  = $clog2(SAMPLE_PERIOD);
  localparam int K_W   = CHAN_MSB - CHAN_LSB + 1;

  // ---------------- SCLK divider ----------------
  logic [DIV_W-1:0] div_cnt;
  logic             sclk_q, tick, rise_en, fall_en;

  assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_en = tick && !sclk_q;
  assign fall_en = tick &&  sclk_q;
  assign SCLK    = sclk_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk_q  <= !sclk_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------- receiver ----------------
  rx_state_e rx_state, rx_next;
  logic [3:0] rx_cnt;
  word_t      rx_sh, new_word;
  logic       rx_done;

  assign new_word = {rx_sh[WORD_W-2:0], SDI};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // SDIFS only matters while idle; a word in flight is dropped when SE falls.
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (rise_en && SE && SDIFS) rx_next = RX_SHIFT;
      RX_SHIFT: begin
        if (!SE) begin
          rx_next = RX_IDLE;
        end else if (rise_en && rx_cnt == 4'd15) begin
          rx_next = RX_IDLE;
          rx_done = 1'b1;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_cnt   <= '0;
      rx_sh    <= WORD_RST;
      rx_word  <= WORD_RST;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      if (rx_state == RX_IDLE) rx_cnt <= '0;
      else if (rise_en) begin
        rx_sh  <= new_word;
        rx_cnt <= rx_cnt + 4'd1;
      end
      if (rx_done) rx_word <= new_word;
    end
  end

  // ---------------- decode, register file, echo queue ----------------
  logic             accept, prog;
  logic [PTR_W-1:0] ptr;
  logic             pend_vld;
  word_t            pend_word;
  logic             echo_start;

  assign accept = rx_done && new_word[CTRL_BIT];
  // Mode words are not echoed: they hand the transmitter over to bursts.
  assign prog   = accept && !new_word[MODE_BIT] && !data_mode;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cfg_regs  <= CFG_RST;
      ptr       <= '0;
      cfg_err   <= 1'b0;
      data_mode <= 1'b0;
      pend_vld  <= 1'b0;
      pend_word <= WORD_RST;
    end else begin
      if (accept && new_word[MODE_BIT]) data_mode <= 1'b1;
      if (prog) begin
        if (ptr < PTR_W'(NUM_REGS)) begin
          cfg_regs[ptr[2:0]*8 +: 8] <= new_word[DATA_MSB:0];
          ptr <= ptr + PTR_W'(1);
        end else begin
          cfg_err <= 1'b1;
        end
        // 1-deep queue: a newer word replaces one still waiting
        pend_vld  <= 1'b1;
        pend_word <= new_word;
      end else if (echo_start) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // ---------------- sample bursts ----------------
  logic [NUM_CH-1:0][SAMP_W-1:0] ch_samp, lat;
  logic [NUM_CH-1:0][3:0]        unused_ch_hi;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_samp[g]      = ch_data[16*g +: SAMP_W];
    assign unused_ch_hi[g] = ch_data[16*g+SAMP_W +: 4];
  end

  logic            tx_busy, tx_start, tx_sdofs, tx_sdo;
  word_t           tx_word;
  logic            run, bursting, first_go, burst_go, next_frame;
  logic [SC_W-1:0] scnt;
  logic [K_W-1:0]  frame_k, nxt_k;
  logic [SAMP_W-1:0] nxt_samp;

  // The sample counter starts once any pending echo has drained, so the
  // first burst never collides with an echo frame.
  assign first_go   = data_mode && !run && !pend_vld && !tx_busy;
  assign burst_go   = fall_en && SE && (first_go || (run && scnt == '0));
  assign next_frame = fall_en && SE && bursting && !tx_busy && !burst_go &&
                      (frame_k != K_W'(NUM_CH - 1));
  assign echo_start = fall_en && SE && pend_vld && !tx_busy && !run;
  assign tx_start   = burst_go || next_frame || echo_start;

  always_comb begin
    nxt_k    = frame_k + K_W'(1);
    nxt_samp = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (nxt_k == K_W'(i)) nxt_samp = lat[i];
  end

  always_comb begin
    tx_word = pend_word;
    if (burst_go)        tx_word = burst_word(K_W'(0), ch_samp[0]);
    else if (next_frame) tx_word = burst_word(nxt_k, nxt_samp);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      run      <= 1'b0;
      scnt     <= '0;
      bursting <= 1'b0;
      frame_k  <= '0;
      lat      <= '0;
    end else begin
      // counter free-runs in data mode regardless of SE
      if (fall_en) begin
        if (first_go)  begin run <= 1'b1; scnt <= SC_W'(1); end
        else if (run)  scnt <= (scnt == SC_W'(SAMPLE_PERIOD - 1)) ? '0 : scnt + SC_W'(1);
      end
      if (!SE) begin
        bursting <= 1'b0;
      end else if (burst_go) begin
        bursting <= 1'b1;
        frame_k  <= '0;
        lat      <= ch_samp;
      end else if (next_frame) begin
        frame_k  <= nxt_k;
      end else if (fall_en && bursting && !tx_busy) begin
        bursting <= 1'b0;
      end
    end
  end

  adc733_sport_txframe u_tx (
    .clk     (clk),
    .rst_l   (rst_l),
    .fall_en (fall_en),
    .start   (tx_start),
    .abort   (!SE),
    .load    (tx_word),
    .busy    (tx_busy),
    .sdofs   (tx_sdofs),
    .sdo     (tx_sdo)
  );

  // SE gates the pins at once; the frame engine is cleared on the next clk.
  assign SDOFS = tx_sdofs && SE;
  assign SDO   = tx_sdo   && SE;

endmodule

// File: tb/tb_adc733_sport_responder.sv
// Self-checking bench for adc733_sport_responder: host-side word sender,
// SDO frame monitor, and a register/echo/burst reference model.
module tb_adc733_sport_responder;
  localparam int NUM_CH = 6;
  localparam int SP     = 256;

  logic clk = 1'b0, rst_l = 1'b1, SDIFS = 1'b0, SDI = 1'b0, SE = 1'b1;
  logic SCLK, SDOFS, SDO, data_mode, rx_valid, cfg_err;
  logic [16*NUM_CH-1:0] ch_data = '0;
  logic [63:0] cfg_regs;
  logic [15:0] rx_word;

  int n_chk = 0, n_fail = 0;

  adc733_sport_responder #(.CLK_DIV(1), .NUM_CH(NUM_CH), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst_l(rst_l), .SCLK(SCLK), .SDIFS(SDIFS), .SDI(SDI), .SE(SE),
    .SDOFS(SDOFS), .SDO(SDO), .ch_data(ch_data), .cfg_regs(cfg_regs),
    .data_mode(data_mode), .rx_word(rx_word), .rx_valid(rx_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_regs [8];
  int          m_ptr;
  bit          m_err, m_dm;
  logic [15:0] exp_echo[$], exp_rx[$];

  function automatic logic [63:0] m_cfg();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_regs[i];
    return r;
  endfunction

  function automatic logic [15:0] bw(input int k, input logic [15:0] ch);
    return 16'h8000 + 16'(k) * 16'h1000 + (ch & 16'h0FFF);
  endfunction

  task automatic model_word(input logic [15:0] w);
    exp_rx.push_back(w);
    if (!w[14]) return;
    if (w[15]) begin m_dm = 1; return; end
    if (m_dm) return;
    if (m_ptr < 8) begin m_regs[m_ptr] = w[7:0]; m_ptr++; end
    else m_err = 1;
    exp_echo.push_back(w);
  endtask

  // ---------------- monitors ----------------
  logic [15:0] fq[$], rq[$];
  int          ft[$];
  int          per = 0, nb = 0, fstart = 0, sync_bad = 0;
  bit          coll = 0;
  logic [15:0] fw = '0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_ptr = 0; m_err = 0; m_dm = 0;
    exp_echo.delete(); exp_rx.delete(); fq.delete(); ft.delete(); rq.delete();
    sync_bad = 0;
  endtask

  always @(posedge SCLK) begin
    #1;
    per++;
    if (!rst_l || !SE) coll = 0;
    else if (coll) begin
      fw = {fw[14:0], SDO};
      if (SDOFS) sync_bad++;
      nb++;
      if (nb == 16) begin fq.push_back(fw); ft.push_back(fstart); coll = 0; end
    end else if (SDOFS) begin
      coll = 1; nb = 0; fstart = per;
    end
  end

  always @(negedge clk) if (rx_valid) rq.push_back(rx_word);

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] w, input int glitch_at, input int nbits);
    @(negedge SCLK); #1 SDIFS = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge SCLK); #1 SDIFS = (i == glitch_at); SDI = w[15-i];
    end
    @(negedge SCLK); #1 SDIFS = 1'b0; SDI = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int g = 0;
    while (fq.size() < n && g < 3000) begin @(negedge clk); g++; end
    chk(tag, 64'(fq.size() >= n), 64'(1));
  endtask

  task automatic wait_per(input int t);
    int g = 0;
    while (per < t && g < 4000) begin @(negedge clk); g++; end
  endtask

  task automatic chk_rx_echo(input string tag);
    chk({tag, "_rxcnt"}, 64'(rq.size()), 64'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rq.size(); i++)
      chk($sformatf("%s_rx%0d", tag, i), 64'(rq[i]), 64'(exp_rx[i]));
    chk({tag, "_echocnt"}, 64'(fq.size()), 64'(exp_echo.size()));
    for (int i = 0; i < exp_echo.size() && i < fq.size(); i++)
      chk($sformatf("%s_echo%0d", tag, i), 64'(fq[i]), 64'(exp_echo[i]));
    chk({tag, "_sync"}, 64'(sync_bad), 64'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sclk"},  64'(SCLK), 64'(0));
    chk({tag, "_sdofs"}, 64'(SDOFS), 64'(0));
    chk({tag, "_sdo"},   64'(SDO), 64'(0));
    chk({tag, "_cfg"},   cfg_regs, 64'(0));
    chk({tag, "_dm"},    64'(data_mode), 64'(0));
    chk({tag, "_rxw"},   64'(rx_word), 64'(0));
    chk({tag, "_rxv"},   64'(rx_valid), 64'(0));
    chk({tag, "_err"},   64'(cfg_err), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] w;
  logic [15:0] rnd[NUM_CH];
  int b0, n1, nbad;
  logic acc;

  initial begin
    model_reset();
    #1 rst_l = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst_l = 1'b1;

    // reset in the middle of a received word
    send(16'h4055, -1, 9);
    rst_l = 1'b0;
    #1 chk_reset_vals("midrst");
    chk("midrst_rxcnt", 64'(rq.size()), 64'(0));
    @(negedge clk); rst_l = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_after_rxcnt", 64'(rq.size()), 64'(0));
    chk("midrst_after_cfg", cfg_regs, 64'(0));
    model_reset();

    // configuration sequence
    for (int i = 0; i < 8; i++) begin
      w = 16'h4000 + 16'(i);
      model_word(w);
      send(w, -1, 16);
      repeat (40) @(negedge clk);
    end
    chk("cfg_seq", cfg_regs, 64'h0706050403020100);
    chk("cfg_seq_err", 64'(cfg_err), 64'(0));
    chk_rx_echo("cfg_seq");

    // ninth program word: file full
    model_word(16'h40AA); send(16'h40AA, -1, 16);
    repeat (40) @(negedge clk);
    chk("extra_cfg", cfg_regs, 64'h0706050403020100);
    chk("extra_err", 64'(cfg_err), 64'(1));
    chk_rx_echo("extra");

    // bad control bit, then SDIFS glitch mid-word
    model_word(16'h0012); send(16'h0012, -1, 16);
    model_word(16'h4321); send(16'h4321, 4, 16);
    repeat (40) @(negedge clk);
    chk("bad_cfg", cfg_regs, m_cfg());
    chk_rx_echo("bad_ovl");

    // randomized program words from a fresh reset
    rst_l = 1'b0; @(negedge clk); rst_l = 1'b1;
    model_reset();
    for (int i = 0; i < 11; i++) begin
      w = 16'($urandom);
      w[15] = 1'b0;
      w[14] = ($urandom_range(0, 4) != 0);
      model_word(w);
      send(w, -1, 16);
    end
    repeat (40) @(negedge clk);
    chk("rand_cfg", cfg_regs, m_cfg());
    chk("rand_err", 64'(cfg_err), 64'(m_err));
    chk_rx_echo("rand");

    // data mode bursts
    for (int k = 0; k < NUM_CH; k++) ch_data[16*k +: 16] = 16'h0100 + 16'(k);
    fq.delete(); ft.delete();
    model_word(16'hC008); send(16'hC008, -1, 16);
    chk("dm_set", 64'(data_mode), 64'(m_dm));
    wait_frames(1, "burst0_first");
    for (int k = 0; k < NUM_CH; k++) begin
      rnd[k] = 16'($urandom);
      ch_data[16*k +: 16] = rnd[k];
    end
    wait_frames(7, "burst1_first");
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("burst0_f%0d", k), 64'(fq[k]), 64'(bw(k, 16'h0100 + 16'(k))));
      chk($sformatf("burst0_t%0d", k), 64'(ft[k] - ft[0]), 64'(17 * k));
    end
    chk("burst_period", 64'(ft[6] - ft[0]), 64'(SP));
    b0 = ft[0];
    model_word(16'h4033); send(16'h4033, -1, 16);
    wait_frames(12, "burst1_done");
    for (int k = 0; k < NUM_CH; k++)
      chk($sformatf("burst1_f%0d", k), 64'(fq[6+k]), 64'(bw(k, rnd[k])));
    chk("dm_cfg", cfg_regs, m_cfg());
    chk("dm_rx_last", 64'(rq[rq.size()-1]), 64'(16'h4033));
    nbad = 0;
    foreach (fq[i]) if (!fq[i][15]) nbad++;
    chk("dm_no_echo", 64'(nbad), 64'(0));

    // SE gating during frame 2 of the third burst
    wait_per(b0 + 2*SP + 2*17 + 6);
    n1 = fq.size();
    chk("se_frames_before", 64'(n1), 64'(14));
    SE = 1'b0;
    #1;
    chk("se_sdo", 64'(SDO), 64'(0));
    chk("se_sdofs", 64'(SDOFS), 64'(0));
    acc = 1'b0;
    repeat (40) begin @(negedge clk); acc |= SDO | SDOFS; end
    chk("se_quiet", 64'(acc), 64'(0));
    wait_per(b0 + 3*SP - 20);
    chk("se_no_partial", 64'(fq.size()), 64'(n1));
    SE = 1'b1;
    wait_frames(n1 + 1, "se_resume");
    chk("se_resume_t", 64'(ft[n1] - b0), 64'(3*SP));
    chk("se_resume_f", 64'(fq[n1]), 64'(bw(0, rnd[0])));
    chk("sync_total", 64'(sync_bad), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
